div512by256: RTL and testbench

- Multi-cycle unsigned divider: 512-bit dividend by 256-bit divisor, producing a 512-bit quotient and a 256-bit remainder.
- Inverse companion to the 256x256 multiplier. Takes the multiplier's 512-bit product as its dividend, for the reduction and inversion paths of the EC point arithmetic datapath.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Same start/busy handshake as the multiplier.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 36 +++
 rtl/div512by256.sv | 145 ++++++++++++++
 tb/tb_div512by256.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 512-by-256 restoring divider.
// Holds the default operand widths, the iteration count and the FSM state encoding.
package div_pkg;

    // Dividend / quotient width.
    localparam int DIV_DW = 512;
    // Divisor / remainder width.
    localparam int DIV_VW = 256;
    // Iteration counter width; 2**DIV_CW must cover DIV_DW iterations.
    localparam int DIV_CW = 10;
    // One quotient bit is produced per iteration.
    localparam int DIV_ITERS = DIV_DW;

    // Divider control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_ITER  = 2'd2,
        S_FINAL = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module div_step #(
    parameter int VW = 256
) (
    input  logic [VW:0]   rem,
    input  logic          din,
    input  logic [VW-1:0] b,
    output logic [VW:0]   rem_next,
    output logic          qbit
);

    logic [VW:0] t_s;
    logic [VW:0] bx_s;
    // The top remainder bit is shifted out by every step; it never reaches t_s.
    logic        unused_rem_top_s;

    assign unused_rem_top_s = rem[VW];

    // Shift in the next dividend bit, then restore or subtract.
    always_comb begin
        t_s      = {rem[VW-1:0], din};
        bx_s     = {1'b0, b};
        rem_next = t_s;
        qbit     = 1'b0;
        if (t_s >= bx_s) begin
            rem_next = t_s - bx_s;
            qbit     = 1'b1;
        end else begin
            rem_next = t_s;
            qbit     = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/div512by256.sv
// Multi-cycle unsigned divider: DW-bit dividend by VW-bit divisor, radix-2
// restoring, one quotient bit per clock. start doubles as an asynchronous
// active-low clear; a new operation needs start low then high again.
// Optional build macro DIV_ZERO_DETECT_EN adds the dz output and a one-cycle
// shortcut for a zero divisor.
module div512by256
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW,
    parameter int CW = DIV_CW
) (
    input  logic          clk,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic          busy,
    output logic [DW-1:0] Q,
`ifdef DIV_ZERO_DETECT_EN
    output logic [VW-1:0] R,
    output logic          dz
`else
    output logic [VW-1:0] R
`endif
);

    div_state_t    state_r;
    div_state_t    state_s;
    logic          busy_r;
    logic          busy_s;
    // Q register doubles as the dividend shift register while iterating.
    logic [DW-1:0] q_r;
    logic [DW-1:0] q_s;
    logic [VW-1:0] r_r;
    logic [VW-1:0] r_s;
    // Partial remainder carries one extra bit so the compare cannot overflow.
    logic [VW:0]   rem_r;
    logic [VW:0]   rem_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [VW:0]   step_rem_s;
    logic          step_qbit_s;
`ifdef DIV_ZERO_DETECT_EN
    logic          dz_r;
    logic          dz_s;
`endif

    div_step #(
        .VW(VW)
    ) u_step (
        .rem      (rem_r),
        .din      (q_r[DW-1]),
        .b        (B),
        .rem_next (step_rem_s),
        .qbit     (step_qbit_s)
    );

    // Next-state and datapath update for every control state.
    always_comb begin
        state_s = state_r;
        busy_s  = busy_r;
        q_s     = q_r;
        r_s     = r_r;
        rem_s   = rem_r;
        cnt_s   = cnt_r;
`ifdef DIV_ZERO_DETECT_EN
        dz_s    = dz_r;
`endif
        case (state_r)
            // Any edge seen outside reset means start is high: load operands.
            S_IDLE, S_INIT: begin
                busy_s  = 1'b1;
                q_s     = A;
                rem_s   = {(VW+1){1'b0}};
                cnt_s   = {CW{1'b0}};
                state_s = S_ITER;
`ifdef DIV_ZERO_DETECT_EN
                if (B == {VW{1'b0}}) begin
                    // Same answer the full iteration would give, in one cycle.
                    dz_s    = 1'b1;
                    q_s     = {DW{1'b1}};
                    r_s     = A[VW-1:0];
                    rem_s   = {1'b0, A[VW-1:0]};
                    state_s = S_FINAL;
                end else begin
                    dz_s    = 1'b0;
                end
`endif
            end
            S_ITER: begin
                rem_s = step_rem_s;
                q_s   = {q_r[DW-2:0], step_qbit_s};
                cnt_s = cnt_r + CW'(1'b1);
                if (cnt_r == CW'(DW - 1)) begin
                    state_s = S_FINAL;
                end else begin
                    state_s = S_ITER;
                end
            end
            // Publish the remainder and hold until start is dropped.
            S_FINAL: begin
                busy_s  = 1'b0;
                r_s     = rem_r[VW-1:0];
                state_s = S_FINAL;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; start low clears everything immediately.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            q_r     <= {DW{1'b0}};
            r_r     <= {VW{1'b0}};
            rem_r   <= {(VW+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
            dz_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            q_r     <= q_s;
            r_r     <= r_s;
            rem_r   <= rem_s;
            cnt_r   <= cnt_s;
`ifdef DIV_ZERO_DETECT_EN
            dz_r    <= dz_s;
`endif
        end
    end

    assign busy = busy_r;
    assign Q    = q_r;
    assign R    = r_r;
`ifdef DIV_ZERO_DETECT_EN
    assign dz   = dz_r;
`endif

endmodule : div512by256

// File: tb/tb_div512by256.sv
// Self-checking bench for div512by256: directed cases plus random operands,
// compared against plain-arithmetic division inside the bench.
module tb_div512by256;

    localparam int DW = 512;
    localparam int VW = 256;
    localparam int NRAND = 40;

    logic          clk = 1'b0;
    logic          start;
    logic [DW-1:0] A;
    logic [VW-1:0] B;
    logic          busy;
    logic [DW-1:0] Q;
    logic [VW-1:0] R;
`ifdef DIV_ZERO_DETECT_EN
    logic          dz;
`endif

    int checks   = 0;
    int failures = 0;

    div512by256 dut (
        .clk   (clk),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .Q     (Q),
`ifdef DIV_ZERO_DETECT_EN
        .R     (R),
        .dz    (dz)
`else
        .R     (R)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference: plain unsigned division; zero divisor yields all ones / low dividend bits.
    task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] q, output logic [VW-1:0] r);
        logic [DW-1:0] bz;
        logic [DW-1:0] rz;
        bz = {{(DW-VW){1'b0}}, b};
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q  = a / bz;
            rz = a % bz;
            r  = rz[VW-1:0];
        end
    endtask

    // Launch one operation from a clean clear; report busy length and results.
    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          output logic [DW-1:0] q_o, output logic [VW-1:0] r_o);
        int            cyc;
        int            exp_cyc;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic [767:0]  recon;
        @(negedge clk);
        start = 1'b0;
        A = a;
        B = b;
        #1;
        chk({tag, ":clr_busy"}, 768'(busy), 768'(0));
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (busy) cyc++;
            else if (cyc > 0) break;
        end
        exp_cyc = 513;
`ifdef DIV_ZERO_DETECT_EN
        if (b == '0) exp_cyc = 1;
        chk({tag, ":dz"}, 768'(dz), 768'(b == '0));
`endif
        model(a, b, eq, er);
        chk({tag, ":busy_cycles"}, 768'(cyc), 768'(exp_cyc));
        chk({tag, ":Q"}, 768'(Q), 768'(eq));
        chk({tag, ":R"}, 768'(R), 768'(er));
        if (b != '0) begin
            recon = 768'(Q) * 768'(B) + 768'(R);
            chk({tag, ":QB+R"}, recon, 768'(a));
            chk({tag, ":R<B"}, 768'(R < b), 768'(1));
        end
        q_o = Q;
        r_o = R;
    endtask

    initial begin
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] m;

        // Reset state.
        start = 1'b0;
        A = '0;
        B = '0;
        #2;
        chk("reset:busy", 768'(busy), 768'(0));
        chk("reset:Q", 768'(Q), 768'(0));
        chk("reset:R", 768'(R), 768'(0));
`ifdef DIV_ZERO_DETECT_EN
        chk("reset:dz", 768'(dz), 768'(0));
`endif

        // 100 / 7, then hold in the final state with start still high.
        run_op("d100_7", 512'd100, 256'd7, q, r);
        chk("d100_7:Q14", 768'(q), 768'(14));
        chk("d100_7:R2", 768'(r), 768'(2));
        repeat (5) @(posedge clk);
        #1;
        chk("hold:busy", 768'(busy), 768'(0));
        chk("hold:Q", 768'(Q), 768'(14));
        chk("hold:R", 768'(R), 768'(2));

        // (2^256-1)^2 / (2^256-1).
        m = '1;
        a = 512'(m) * 512'(m);
        run_op("max_sq", a, m, q, r);
        chk("max_sq:Qm", 768'(q), 768'(m));
        chk("max_sq:R0", 768'(r), 768'(0));

        // Dividend smaller than divisor.
        b = '0;
        b[VW-1] = 1'b1;
        run_op("small", 512'd5, b, q, r);
        chk("small:Q0", 768'(q), 768'(0));
        chk("small:R5", 768'(r), 768'(5));

        // Divide by one.
        a = rand_wide();
        run_op("div1", a, 256'd1, q, r);
        chk("div1:QA", 768'(q), 768'(a));

        // Abort mid-operation: the clear is asynchronous.
        @(negedge clk);
        start = 1'b0;
        A = rand_wide();
        B = 256'd3;
        @(negedge clk);
        start = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        start = 1'b0;
        #1;
        chk("abort:busy", 768'(busy), 768'(0));
        chk("abort:Q", 768'(Q), 768'(0));
        chk("abort:R", 768'(R), 768'(0));
        run_op("after_abort", 512'd100, 256'd7, q, r);
        chk("after_abort:Q14", 768'(q), 768'(14));
        chk("after_abort:R2", 768'(r), 768'(2));

        // Zero divisor.
        run_op("divzero", 512'd12345, 256'd0, q, r);
        chk("divzero:Qones", 768'(q), 768'({DW{1'b1}}));
        chk("divzero:R", 768'(r), 768'(12345));

        // Random operands with varied divisor magnitude.
        for (int n = 0; n < NRAND; n++) begin
            a = rand_wide();
            b = rand_wide() >> $urandom_range(0, VW - 1);
            if ((n % 4) == 0) a = a >> $urandom_range(0, DW - 1);
            run_op($sformatf("rand%0d", n), a, b, q, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div512by256
